// File: rtl/axi_ax_buffer_ng.sv
// AXI address-channel (AW/AR) buffer: circular FIFO with optional fall-through,
// fill level, almost-full flag and synchronous flush. Depth 0 is a wire-through.
module axi_ax_buffer_ng #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int USER_WIDTH   = 6,
    parameter int BUFFER_DEPTH = 2,
    parameter int FALL_THROUGH = 0,
    parameter int AF_THRESH    = 1,
    localparam int CNT_W       = (BUFFER_DEPTH > 0) ? $clog2(BUFFER_DEPTH + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  slave_valid_i,
    input  logic [ADDR_WIDTH-1:0] slave_addr_i,
    input  logic [7:0]            slave_len_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic [21:0]           slave_attr_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [ADDR_WIDTH-1:0] master_addr_o,
    output logic [7:0]            master_len_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [21:0]           master_attr_o,
    input  logic                  master_ready_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  almost_full_o
);

    localparam int PW = 30 + ADDR_WIDTH + USER_WIDTH + ID_WIDTH;

    logic [PW-1:0] w_slave_payload;
    logic [PW-1:0] w_master_payload;

    assign w_slave_payload = {slave_attr_i, slave_len_i, slave_id_i, slave_user_i, slave_addr_i};
    assign {master_attr_o, master_len_o, master_id_o, master_user_o, master_addr_o} =
        w_master_payload;

    if (BUFFER_DEPTH == 0) begin : g_wire
        // No storage: the buffer degenerates to a plain connection.
        logic w_unused;
        assign w_unused         = ^{clk_i, rst_i, flush_i};
        assign w_master_payload = w_slave_payload;
        assign master_valid_o   = slave_valid_i;
        assign slave_ready_o    = master_ready_i;
        assign count_o          = '0;
        assign almost_full_o    = 1'b0;
    end else begin : g_fifo
        localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
        localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);
        localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

        logic [PW-1:0]    r_mem [BUFFER_DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_count;

        logic w_full;
        logic w_empty;
        logic w_bypass;
        logic w_push;
        logic w_pop;
        logic w_bypass_take;
        logic w_do_wr;
        logic w_do_rd;

        function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            return (p == LAST_PTR) ? '0 : p + 1'b1;
        endfunction

        assign w_full   = (r_count == FULL_CNT);
        assign w_empty  = (r_count == '0);
        assign w_bypass = (FALL_THROUGH != 0) && w_empty;

        // Ready depends only on local state, never on master_ready_i.
        assign slave_ready_o  = !w_full && !flush_i && !rst_i;
        assign master_valid_o = (w_bypass ? slave_valid_i : !w_empty) && !flush_i && !rst_i;

        assign w_push = slave_valid_i && slave_ready_o;
        assign w_pop  = master_valid_o && master_ready_i;

        // Fall-through entry consumed in the same cycle never touches the memory.
        assign w_bypass_take = w_bypass && w_push && master_ready_i;
        assign w_do_wr       = w_push && !w_bypass_take;
        assign w_do_rd       = w_pop && !w_bypass_take;

        assign w_master_payload = w_bypass ? w_slave_payload : r_mem[r_rd_ptr];
        assign count_o          = r_count;
        assign almost_full_o    = (r_count >= AF_CNT);

        // Pointer and occupancy update; flush and reset both clear the queue.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_do_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
                if (w_do_wr && !w_do_rd) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_do_wr && w_do_rd) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end

        // Payload storage; no reset needed since validity lives in r_count.
        always_ff @(posedge clk_i) begin
            if (w_do_wr) r_mem[r_wr_ptr] <= w_slave_payload;
        end

        // Overflow / underflow guards.
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                assert (!(w_push && w_full));
                assert (!(w_do_rd && w_empty));
            end
        end
    end

endmodule

// File: tb/tb_axi_ax_buffer_ng.sv
module tb_axi_ax_buffer_ng;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        sv;
    logic [31:0] saddr;
    logic [7:0]  slen;
    logic [3:0]  sid;
    logic [5:0]  suser;
    logic [21:0] sattr;
    logic        mr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Per-instance outputs: d2 = depth 2, d3 = depth 3, d4 = depth 4 fall-through, d0 = wire.
    logic        o2_rdy, o2_vld, o2_af;
    logic [31:0] o2_addr;
    logic [7:0]  o2_len;
    logic [3:0]  o2_id;
    logic [5:0]  o2_user;
    logic [21:0] o2_attr;
    logic [1:0]  o2_cnt;

    logic        o3_rdy, o3_vld, o3_af;
    logic [31:0] o3_addr;
    logic [7:0]  o3_len;
    logic [3:0]  o3_id;
    logic [5:0]  o3_user;
    logic [21:0] o3_attr;
    logic [1:0]  o3_cnt;

    logic        o4_rdy, o4_vld, o4_af;
    logic [31:0] o4_addr;
    logic [7:0]  o4_len;
    logic [3:0]  o4_id;
    logic [5:0]  o4_user;
    logic [21:0] o4_attr;
    logic [2:0]  o4_cnt;

    logic        o0_rdy, o0_vld, o0_af;
    logic [31:0] o0_addr;
    logic [7:0]  o0_len;
    logic [3:0]  o0_id;
    logic [5:0]  o0_user;
    logic [21:0] o0_attr;
    logic [0:0]  o0_cnt;

    axi_ax_buffer_ng #(.BUFFER_DEPTH(2), .FALL_THROUGH(0), .AF_THRESH(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .slave_valid_i(sv),
        .slave_addr_i(saddr), .slave_len_i(slen), .slave_id_i(sid), .slave_user_i(suser),
        .slave_attr_i(sattr), .slave_ready_o(o2_rdy), .master_valid_o(o2_vld),
        .master_addr_o(o2_addr), .master_len_o(o2_len), .master_id_o(o2_id),
        .master_user_o(o2_user), .master_attr_o(o2_attr), .master_ready_i(mr),
        .count_o(o2_cnt), .almost_full_o(o2_af)
    );

    axi_ax_buffer_ng #(.BUFFER_DEPTH(3), .FALL_THROUGH(0), .AF_THRESH(2)) u_d3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .slave_valid_i(sv),
        .slave_addr_i(saddr), .slave_len_i(slen), .slave_id_i(sid), .slave_user_i(suser),
        .slave_attr_i(sattr), .slave_ready_o(o3_rdy), .master_valid_o(o3_vld),
        .master_addr_o(o3_addr), .master_len_o(o3_len), .master_id_o(o3_id),
        .master_user_o(o3_user), .master_attr_o(o3_attr), .master_ready_i(mr),
        .count_o(o3_cnt), .almost_full_o(o3_af)
    );

    axi_ax_buffer_ng #(.BUFFER_DEPTH(4), .FALL_THROUGH(1), .AF_THRESH(3)) u_d4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .slave_valid_i(sv),
        .slave_addr_i(saddr), .slave_len_i(slen), .slave_id_i(sid), .slave_user_i(suser),
        .slave_attr_i(sattr), .slave_ready_o(o4_rdy), .master_valid_o(o4_vld),
        .master_addr_o(o4_addr), .master_len_o(o4_len), .master_id_o(o4_id),
        .master_user_o(o4_user), .master_attr_o(o4_attr), .master_ready_i(mr),
        .count_o(o4_cnt), .almost_full_o(o4_af)
    );

    axi_ax_buffer_ng #(.BUFFER_DEPTH(0)) u_d0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .slave_valid_i(sv),
        .slave_addr_i(saddr), .slave_len_i(slen), .slave_id_i(sid), .slave_user_i(suser),
        .slave_attr_i(sattr), .slave_ready_o(o0_rdy), .master_valid_o(o0_vld),
        .master_addr_o(o0_addr), .master_len_o(o0_len), .master_id_o(o0_id),
        .master_user_o(o0_user), .master_attr_o(o0_attr), .master_ready_i(mr),
        .count_o(o0_cnt), .almost_full_o(o0_af)
    );

    // Reference queue for the depth-3 instance.
    logic [71:0] q[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] mk(input logic [31:0] a, input logic [7:0] l,
                                       input logic [3:0] i, input logic [5:0] u,
                                       input logic [21:0] at);
        return {at, l, i, u, a};
    endfunction

    function automatic logic [71:0] rand_payload();
        return {22'($urandom), 8'($urandom), 4'($urandom), 6'($urandom), 32'($urandom)};
    endfunction

    task automatic drive(input logic v, input logic r, input logic [71:0] p);
        sv = v;
        mr = r;
        {sattr, slen, sid, suser, saddr} = p;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    // One cycle on the depth-3 instance, checked against the reference queue.
    task automatic d3_cycle(input logic v, input logic r, input logic [71:0] p,
                            output logic pushed);
        logic exp_rdy;
        logic exp_vld;
        drive(v, r, p);
        #1;
        exp_rdy = (q.size() < 3);
        exp_vld = (q.size() > 0);
        chk("d3_ready", o3_rdy, exp_rdy);
        chk("d3_valid", o3_vld, exp_vld);
        if (exp_vld) chk("d3_head", {o3_attr, o3_len, o3_id, o3_user, o3_addr}, q[0]);
        pushed = v && exp_rdy;
        tick();
        if (exp_vld && r) void'(q.pop_front());
        if (pushed) q.push_back(p);
        chk("d3_count", o3_cnt, q.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pushed;
        logic [71:0] p;
        int          sent;
        int          cyc;

        // ---------------- reset state, then stream on depth 2 ----------------
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, 1'b0, mk(32'h1000, 8'h00, 4'h1, 6'h00, 22'h0));
        tick();
        tick();
        chk("rst_ready_d2", o2_rdy, 1'b0);
        chk("rst_count_d2", o2_cnt, 2'd0);
        chk("rst_valid_d2", o2_vld, 1'b0);
        chk("rst_af_d2", o2_af, 1'b0);
        chk("rst_valid_d4_ft", o4_vld, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready_d2", o2_rdy, 1'b1);
        chk("post_rst_count_d2", o2_cnt, 2'd0);
        chk("post_rst_valid_d2", o2_vld, 1'b0);
        tick();
        chk("pushA_count", o2_cnt, 2'd1);
        chk("pushA_valid", o2_vld, 1'b1);
        chk("pushA_addr", o2_addr, 32'h1000);
        chk("pushA_af", o2_af, 1'b0);
        drive(1'b1, 1'b0, mk(32'h2000, 8'h00, 4'h2, 6'h00, 22'h0));
        tick();
        chk("pushB_count", o2_cnt, 2'd2);
        chk("pushB_ready", o2_rdy, 1'b0);
        chk("pushB_af", o2_af, 1'b1);
        chk("pushB_head_stable", o2_addr, 32'h1000);
        drive(1'b0, 1'b1, '0);
        #1;
        chk("popA_addr", o2_addr, 32'h1000);
        tick();
        chk("popB_addr", o2_addr, 32'h2000);
        chk("popB_valid", o2_vld, 1'b1);
        chk("popB_count", o2_cnt, 2'd1);
        tick();
        chk("drained_valid", o2_vld, 1'b0);
        chk("drained_count", o2_cnt, 2'd0);

        // ---------------- depth 3: full with simultaneous pop ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d3_cycle(1'b1, 1'b0, mk(32'h3000 + i, 8'(i), 4'(i), 6'(i), 22'(i)), pushed);
        end
        chk("full_count", o3_cnt, 2'd3);
        p = mk(32'h3003, 8'h3, 4'h3, 6'h3, 22'h3);
        d3_cycle(1'b1, 1'b1, p, pushed);
        chk("full_pop_no_push", pushed, 1'b0);
        chk("full_pop_count", o3_cnt, 2'd2);
        d3_cycle(1'b1, 1'b0, p, pushed);
        chk("refill_count", o3_cnt, 2'd3);

        // 100 random entries through the reference queue.
        sent = 0;
        cyc  = 0;
        p    = rand_payload();
        while (sent < 100 && cyc < 2000) begin
            d3_cycle(1'b1, ($urandom_range(0, 1) != 0), p, pushed);
            if (pushed) begin
                sent++;
                p = rand_payload();
            end
            cyc++;
        end
        chk("rand_all_sent", sent, 100);
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            d3_cycle(1'b0, 1'b1, '0, pushed);
            cyc++;
        end
        chk("rand_drained", o3_cnt, 2'd0);

        // ---------------- depth 3 wrap-around with full-width fields ----------------
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 40) begin
            p = mk(32'hA000_0000 + sent, 8'hFF, 4'(sent), 6'h3F ^ 6'(sent),
                   (sent == 0) ? 22'h3F_FFFF : (sent[0] ? 22'h2A_AAAA : 22'h15_5555));
            d3_cycle(1'b1, (cyc > 0), p, pushed);
            if (pushed) sent++;
            cyc++;
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            d3_cycle(1'b0, 1'b1, '0, pushed);
            cyc++;
        end
        chk("wrap_drained", o3_cnt, 2'd0);

        // ---------------- depth 4 fall-through ----------------
        do_reset();
        drive(1'b1, 1'b1, mk(32'h4000, 8'h01, 4'h5, 6'h05, 22'h5));
        #1;
        chk("ft_same_cycle_valid", o4_vld, 1'b1);
        chk("ft_same_cycle_id", o4_id, 4'h5);
        chk("ft_same_cycle_addr", o4_addr, 32'h4000);
        tick();
        chk("ft_taken_count", o4_cnt, 3'd0);
        drive(1'b1, 1'b0, mk(32'h4100, 8'h02, 4'h6, 6'h06, 22'h6));
        #1;
        chk("ft_held_valid", o4_vld, 1'b1);
        tick();
        chk("ft_held_count", o4_cnt, 3'd1);
        drive(1'b0, 1'b0, mk(32'h4200, 8'h03, 4'h7, 6'h07, 22'h7));
        #1;
        chk("ft_stable_id", o4_id, 4'h6);
        chk("ft_stable_addr", o4_addr, 32'h4100);
        tick();
        chk("ft_stable_id2", o4_id, 4'h6);
        chk("ft_stable_valid2", o4_vld, 1'b1);
        mr = 1'b1;
        tick();
        chk("ft_popped_count", o4_cnt, 3'd0);
        chk("ft_popped_valid", o4_vld, 1'b0);

        // ---------------- depth 4 flush mid-operation ----------------
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, mk(32'h5000 + i, 8'h0, 4'(i), 6'h0, 22'h0));
            tick();
        end
        chk("pre_flush_count", o4_cnt, 3'd3);
        chk("pre_flush_af", o4_af, 1'b1);
        chk("pre_flush_head", o4_id, 4'h1);
        flush = 1'b1;
        drive(1'b1, 1'b1, mk(32'h5555, 8'h0, 4'hE, 6'h0, 22'h0));
        #1;
        chk("flush_ready", o4_rdy, 1'b0);
        chk("flush_valid", o4_vld, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, '0);
        #1;
        chk("post_flush_count", o4_cnt, 3'd0);
        chk("post_flush_af", o4_af, 1'b0);
        chk("post_flush_valid", o4_vld, 1'b0);
        drive(1'b1, 1'b0, mk(32'h5900, 8'h0, 4'h9, 6'h0, 22'h0));
        tick();
        drive(1'b0, 1'b0, '0);
        #1;
        chk("fresh_head_id", o4_id, 4'h9);
        chk("fresh_head_count", o4_cnt, 3'd1);

        // ---------------- reset mid-burst on depth 2 ----------------
        do_reset();
        drive(1'b1, 1'b0, mk(32'h6000, 8'h0, 4'h1, 6'h0, 22'h0));
        tick();
        tick();
        chk("midrst_pre_count", o2_cnt, 2'd2);
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk("midrst_valid_low", o2_vld, 1'b0);
        chk("midrst_ready_low", o2_rdy, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_count", o2_cnt, 2'd0);
        chk("midrst_valid", o2_vld, 1'b0);

        // ---------------- zero depth wire-through ----------------
        for (int i = 0; i < 8; i++) begin
            p = rand_payload();
            flush = i[0];
            drive(i[1], i[2] ^ i[0], p);
            #1;
            chk("d0_valid", o0_vld, i[1]);
            chk("d0_ready", o0_rdy, i[2] ^ i[0]);
            chk("d0_payload", {o0_attr, o0_len, o0_id, o0_user, o0_addr}, p);
            chk("d0_count", o0_cnt, 1'b0);
            chk("d0_af", o0_af, 1'b0);
            tick();
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ax_buffer_ng.md
Name: axi_ax_buffer_ng

Overview:
Next-generation address-channel (AW/AR) buffer for the AXI4 interconnect master slices. It is a self-contained circular FIFO, not a wrapper around an external FIFO, with:
- parametrised depth, including a zero-depth wire-through mode;
- an optional fall-through mode;
- fill-level and almost-full status outputs;
- a synchronous flush.

It sits between a slave port and the interconnect crossbar on either address channel. It is used for both AW and AR instances.

Parameters:
ID_WIDTH, 4, width of the AxID field
ADDR_WIDTH, 32, width of the AxADDR field
USER_WIDTH, 6, width of the AxUSER field
BUFFER_DEPTH, 2, number of entries; 0 = combinational pass-through, legal range 0..64
FALL_THROUGH, 0, 1 = an empty buffer forwards input to output in the same cycle
AF_THRESH, 1, almost_full_o asserts when count_o >= AF_THRESH; legal range 1..BUFFER_DEPTH
CNT_W, $clog2(BUFFER_DEPTH+1), width of count_o (localparam; minimum 1)

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  synchronous flush; discards all stored entries
slave_valid_i  in  1  request valid
slave_addr_i  in  ADDR_WIDTH  AxADDR
slave_len_i  in  8  AxLEN
slave_id_i  in  ID_WIDTH  AxID
slave_user_i  in  USER_WIDTH  AxUSER
slave_attr_i  in  22  packed {cache[21:18], prot[17:14], lock[13], burst[12:11], size[10:8], qos[7:4], region[3:0]}
slave_ready_o  out  1  buffer accepts a request
master_valid_o  out  1  head entry valid
master_addr_o  out  ADDR_WIDTH  head AxADDR
master_len_o  out  8  head AxLEN
master_id_o  out  ID_WIDTH  head AxID
master_user_o  out  USER_WIDTH  head AxUSER
master_attr_o  out  22  head attributes, same packing as slave_attr_i
master_ready_i  in  1  downstream accepts the head entry
count_o  out  CNT_W  number of stored entries
almost_full_o  out  1  count_o >= AF_THRESH

Behaviour:
- Reset: clock is clk_i; reset is rst_i, synchronous and active-high. While rst_i is high and on the cycle after, count_o = 0, master_valid_o = 0, almost_full_o = 0, and the read and write pointers are 0.
  - slave_ready_o = 0 while rst_i = 1; it is 1 on the first cycle after rst_i falls (BUFFER_DEPTH >= 1).
  - The master data outputs are don't-care while master_valid_o = 0.
- Handshakes:
  - Push = slave_valid_i & slave_ready_o.
  - Pop = master_valid_o & master_ready_i.
  - The payload is stored bit-exact as 30 + ADDR_WIDTH + USER_WIDTH + ID_WIDTH bits.
  - Once master_valid_o is asserted, it and the head data stay stable until popped (AXI rule), unless flush_i or rst_i is asserted.
- slave_ready_o = !full & !flush_i & !rst_i.
  - It never depends on master_ready_i: no ready-to-ready combinational path.
  - When full, a same-cycle pop does not free a slot for a push; the slot frees on the next cycle.
- Normal mode (FALL_THROUGH = 0):
  - master_valid_o = (count != 0) & !flush_i.
  - Data comes from the memory at rd_ptr.
  - Push-to-valid latency is 1 cycle.
  - The master outputs are driven only from registers/memory.
- Fall-through mode (FALL_THROUGH = 1), when count == 0:
  - master_valid_o = slave_valid_i & !flush_i, and the master outputs take the slave inputs combinationally.
  - If master_ready_i is also high, the entry is not written and count stays 0.
  - If it is not high, the entry is written normally.
  - When count != 0, behaviour is identical to normal mode.
- Pointers:
  - wr_ptr/rd_ptr increment modulo BUFFER_DEPTH and wrap from BUFFER_DEPTH-1 to 0; non-power-of-2 depths are legal.
  - count: push only → +1; pop only → -1; push & pop → unchanged.
  - Full = (count == BUFFER_DEPTH); empty = (count == 0).
- Overflow/underflow cannot occur, because push is gated by !full and pop by valid. The implementation carries an assertion on both conditions.
- flush_i:
  - In the flush cycle, slave_ready_o = 0 and master_valid_o = 0, so no handshake completes.
  - On the next edge, count, wr_ptr and rd_ptr go to 0.
  - flush_i and rst_i together behave as reset.
- BUFFER_DEPTH = 0:
  - The master outputs equal the slave inputs, master_valid_o = slave_valid_i, and slave_ready_o = master_ready_i.
  - count_o = 0 and almost_full_o = 0; flush_i is ignored.
  - FALL_THROUGH and AF_THRESH are ignored.
- almost_full_o is registered-equivalent: it is a pure function of the count register, with no combinational input path.

Test Plan:
- Reset then stream: DEPTH=2, FT=0; push A=0x1000, B=0x2000 back-to-back with master_ready_i=0 → slave_ready_o=0 after 2 pushes, count_o=2, almost_full_o=1; raise master_ready_i → A then B on consecutive cycles, count_o returns to 0.
- Full with simultaneous pop: DEPTH=3, full, slave_valid_i=1, master_ready_i=1 → no push that cycle (slave_ready_o=0), count 3→2; push accepted the next cycle, count back to 3; order preserved over 100 random IDs, checked against a scoreboard.
- Fall-through: DEPTH=4, FT=1, empty, slave_valid_i=1, id=0x5, master_ready_i=1 → master_valid_o=1 with id 0x5 in the same cycle, count_o stays 0; with master_ready_i=0 → count_o=1 and the entry is held stable.
- Wrap-around, non-power-of-2: DEPTH=3, 10 pushes/pops interleaved so pointers wrap 3 times → every field, including all 22 attr bits and len=0xFF, emerges bit-exact and in order.
- Flush mid-operation: DEPTH=4 holding 3 entries, assert flush_i with slave_valid_i=1 → no handshake that cycle, count_o=0 next cycle; the next push appears as a fresh head.
- Reset mid-burst and zero depth: rst_i high with 2 entries stored → count_o=0, master_valid_o=0 the next cycle. DEPTH=0 → outputs mirror inputs and slave_ready_o tracks master_ready_i every cycle.
